// File: rtl/fuzzification_2.sv
// Crisp-to-fuzzy front end: forms ec from successive error samples and maps e/ec
// onto 17-level fuzzy indices (0 = +8, 8 = ZE, 16 = -8) through a two-stage pipeline.
module fuzzification_2 #(
   parameter int IN_W     = 16,
   parameter int E_SHIFT  = 8,
   parameter int EC_SHIFT = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   in_valid,
   input  logic signed [IN_W-1:0] in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4:0]             fuzzy_e,
   output logic [4:0]             fuzzy_ec,
   output logic                   sat_flag,
   output logic [7:0]             sat_cnt
);

   // Valid/ready: a word moves when valid && ready are both high at a rising edge;
   // the output pair stays frozen while out_valid && !out_ready.

   localparam logic signed [IN_W:0] Q_MAX = (IN_W+1)'(8);
   localparam logic signed [IN_W:0] Q_MIN = -Q_MAX;

   // Returns {clipped, index}; floor comes from the arithmetic shift.
   function automatic logic [5:0] quantize(input logic signed [IN_W:0] v,
                                           input int unsigned sh);
      logic signed [IN_W:0] q;
      logic signed [4:0]    qs;
      logic                 clip;
      q    = v >>> sh;
      clip = 1'b1;
      if (q > Q_MAX)      qs = 5'sd8;
      else if (q < Q_MIN) qs = -5'sd8;
      else begin
         qs   = q[4:0];
         clip = 1'b0;
      end
      return {clip, 5'd8 - qs};
   endfunction

   logic                   s1_valid_q, s1_valid_d;
   logic signed [IN_W-1:0] e1_q, e1_d;
   logic signed [IN_W:0]   ec1_q, ec1_d;
   logic signed [IN_W-1:0] e_prev_q, e_prev_d;
   logic                   first_q, first_d;
   logic                   out_valid_q, out_valid_d;
   logic [4:0]             fe_q, fe_d;
   logic [4:0]             fec_q, fec_d;
   logic                   sat_q, sat_d;
   logic [7:0]             cnt_q, cnt_d;

   logic       out_adv;
   logic       in_xfer;
   logic [5:0] qe;
   logic [5:0] qec;

   assign out_adv  = !out_valid_q || out_ready;
   assign in_ready = rst_n && (!s1_valid_q || out_adv);
   assign in_xfer  = in_valid && in_ready;
   assign qe       = quantize({e1_q[IN_W-1], e1_q}, E_SHIFT);
   assign qec      = quantize(ec1_q, EC_SHIFT);

   always_comb begin
      s1_valid_d  = s1_valid_q;
      e1_d        = e1_q;
      ec1_d       = ec1_q;
      e_prev_d    = e_prev_q;
      first_d     = first_q;
      out_valid_d = out_valid_q;
      fe_d        = fe_q;
      fec_d       = fec_q;
      sat_d       = sat_q;
      cnt_d       = cnt_q;
      if (clear) begin
         // Flush wins over a same-cycle input transfer; sat_cnt survives.
         s1_valid_d  = 1'b0;
         out_valid_d = 1'b0;
         first_d     = 1'b1;
         e_prev_d    = '0;
      end else begin
         if (in_xfer) begin
            e1_d       = in_data;
            ec1_d      = first_q ? '0
                       : ({in_data[IN_W-1], in_data} - {e_prev_q[IN_W-1], e_prev_q});
            e_prev_d   = in_data;
            first_d    = 1'b0;
            s1_valid_d = 1'b1;
         end else if (out_adv) begin
            s1_valid_d = 1'b0;
         end
         if (out_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
               fe_d  = qe[4:0];
               fec_d = qec[4:0];
               sat_d = qe[5] | qec[5];
               if ((qe[5] | qec[5]) && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         e1_q        <= '0;
         ec1_q       <= '0;
         e_prev_q    <= '0;
         first_q     <= 1'b1;
         out_valid_q <= 1'b0;
         fe_q        <= 5'd8;
         fec_q       <= 5'd8;
         sat_q       <= 1'b0;
         cnt_q       <= 8'd0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         e1_q        <= e1_d;
         ec1_q       <= ec1_d;
         e_prev_q    <= e_prev_d;
         first_q     <= first_d;
         out_valid_q <= out_valid_d;
         fe_q        <= fe_d;
         fec_q       <= fec_d;
         sat_q       <= sat_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign fuzzy_e   = fe_q;
   assign fuzzy_ec  = fec_q;
   assign sat_flag  = sat_q;
   assign sat_cnt   = cnt_q;

endmodule

// File: doc/fuzzification_2.md
Name: fuzzification_2

Overview:
- Crisp-to-fuzzy front end for the phase-2 fuzzy controller; the inverse direction of the phase-2 output defuzzifier.
- Accepts a stream of signed crisp error samples, forms the error change (ec) against the previous accepted sample, and quantizes e and ec into 17-level fuzzy indices (0..16) for the rule table.
- Index convention matches the phase-2 defuzzifier: index 0 = most positive (+8), index 8 = ZE, index 16 = most negative (-8).
- Valid/ready streaming, two register stages, full backpressure support.

Parameters:
- IN_W, 16, width of signed crisp input sample.
- E_SHIFT, 8, arithmetic right-shift applied to e before level saturation (one level = 2^E_SHIFT LSB).
- EC_SHIFT, 6, arithmetic right-shift applied to ec before level saturation.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- clear  in  1  synchronous flush: empties pipeline and forgets ec history.
- in_valid  in  1  crisp sample valid.
- in_data  in  IN_W  signed crisp error sample.
- in_ready  out  1  block can accept a sample this cycle.
- out_valid  out  1  fuzzy pair valid.
- out_ready  in  1  downstream accepts the fuzzy pair.
- fuzzy_e  out  5  fuzzy index of e, 0..16.
- fuzzy_ec  out  5  fuzzy index of ec, 0..16.
- sat_flag  out  1  current output pair had e or ec saturated.
- sat_cnt  out  8  saturating count (stops at 255) of output pairs with sat_flag set.

Behaviour:
- Reset (rst_n=0 at a clock edge): s1_valid=0, out_valid=0, fuzzy_e=fuzzy_ec=5'd8, sat_flag=0, sat_cnt=0, e_prev=0, first=1. in_ready=0 while rst_n=0.
- Handshakes:
  - Input transfer on in_valid&&in_ready.
  - Output transfer on out_valid&&out_ready.
  - out_data is held stable while out_valid&&!out_ready.
- Advance conditions:
  - out_adv = !out_valid || out_ready.
  - in_ready = rst_n && (!s1_valid || out_adv) (combinational).
- Stage 1, on input transfer:
  - e1 = in_data.
  - ec1 = first ? 0 : in_data - e_prev, computed at IN_W+1 bits with no overflow.
  - e_prev <= in_data; first <= 0; s1_valid <= 1.
  - If no input transfer and out_adv, s1_valid <= 0.
- Stage 2, when s1_valid && out_adv:
  - qe = e1 >>> E_SHIFT; qec = ec1 >>> EC_SHIFT. Arithmetic shift, i.e. floor.
  - Each q is saturated to [-8,+8].
  - fuzzy index = 8 - q_sat.
  - sat_flag = either value clipped.
  - out_valid <= 1.
  - sat_cnt increments if sat_flag is set, saturating at 255.
- When out_adv && !s1_valid: out_valid <= 0; data registers keep their old values.
- Latency: 2 cycles from input transfer to out_valid, with no stall. Sustained throughput 1 sample/cycle with out_ready=1.
- Backpressure: with out_ready=0, one sample is held in out and one in s1. in_ready then drops to 0 and no sample is lost or duplicated.
- clear=1 (rst_n=1):
  - s1_valid <= 0, out_valid <= 0, first <= 1, e_prev <= 0.
  - sat_cnt is retained.
  - Any input transfer in the same cycle is discarded; in_ready stays asserted normally.
  - Next accepted sample has ec=0.
- Reset mid-stream: all in-flight samples are dropped; the state is identical to post-reset.
- Boundary: in_data = -2^(IN_W-1) and +2^(IN_W-1)-1 must produce correct floor/saturation, with no wrap in ec.

Test Plan:
- Reset, then send in_data=0 (first sample) -> 2 cycles later out_valid=1, fuzzy_e=8, fuzzy_ec=8, sat_flag=0.
- Follow with in_data=-300 -> fuzzy_e=10 (floor(-300/256)=-2), fuzzy_ec=13 (floor(-300/64)=-5), sat_flag=0.
- Follow with in_data=32767 -> fuzzy_e=0, fuzzy_ec=0 (ec=33067, no wrap), sat_flag=1, sat_cnt=1.
- Send 3 samples back-to-back with out_ready=0 -> in_ready falls after 2 accepted. Release out_ready -> outputs appear in order, exactly 3 pairs, with held data stable during the stall.
- Stream -32768 then 100 -> first pair fuzzy_e=16, sat_flag=1. Then assert clear, send 100 -> fuzzy_e=8, fuzzy_ec=8 (history cleared), sat_cnt unchanged by clear.
- Assert rst_n=0 with both stages full -> next cycle out_valid=0, fuzzy_e=fuzzy_ec=8, sat_cnt=0. The first post-reset sample yields fuzzy_ec=8.
